sdram_arbiter: RTL and testbench



---
 rtl/sdram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
`default_nettype none
// sdram_arbiter (rev 1.0): VGA/CPU arbiter in front of one Avalon-style SDRAM slave, with a read-tag FIFO
// that steers returning data. Optional macro SDRAM_ARB_STARVATION_GUARD_EN bounds back-to-back VGA grants.
module sdram_arbiter #(
   parameter int ADDR_W        = 22,
   parameter int DATA_W        = 16,
   parameter int MAX_PENDING   = 4,
   parameter int VGA_BURST_MAX = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vga_req,
   input  logic [ADDR_W-1:0]   vga_addr,
   output logic                vga_gnt,
   output logic [DATA_W-1:0]   vga_rdata,
   output logic                vga_rvalid,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic [DATA_W/8-1:0] cpu_be,
   output logic                cpu_gnt,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_rvalid,
   output logic [ADDR_W-1:0]   sd_addr,
   output logic [DATA_W/8-1:0] sd_be_n,
   output logic                sd_rd_n,
   output logic                sd_wr_n,
   output logic [DATA_W-1:0]   sd_wdata,
   input  logic                sd_waitrequest,
   input  logic [DATA_W-1:0]   sd_rdata,
   input  logic                sd_rvalid,
   output logic                err_orphan
);

   localparam int   BE_W    = DATA_W / 8;
   localparam int   PTR_W   = $clog2(MAX_PENDING);
   localparam int   CNT_W   = PTR_W + 1;
   localparam logic OWN_VGA = 1'b0;
   localparam logic OWN_CPU = 1'b1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CMD  = 1'b1
   } state_t;

   state_t              r_state;
   logic                r_owner;
   logic                r_we;
   logic [ADDR_W-1:0]   r_sd_addr;
   logic [DATA_W-1:0]   r_sd_wdata;
   logic [BE_W-1:0]     r_sd_be_n;
   logic                r_sd_rd_n;
   logic                r_sd_wr_n;

   logic [MAX_PENDING-1:0] r_tags;
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   logic [CNT_W-1:0]       r_count;
   logic                   r_err_orphan;

   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_have;
   logic w_rd_room;
   logic w_vga_elig;
   logic w_cpu_elig;
   logic w_guard_hit;
   logic w_pick_cpu;
   logic w_head_tag;

   assign w_accept   = (r_state == ST_CMD) && !sd_waitrequest;
   assign w_push     = w_accept && !r_we;
   assign w_have     = (r_count != '0);
   assign w_pop      = sd_rvalid && w_have;
   assign w_rd_room  = (r_count < CNT_W'(MAX_PENDING));
   assign w_vga_elig = vga_req && w_rd_room;
   assign w_cpu_elig = cpu_req && (cpu_we || w_rd_room);
   assign w_pick_cpu = w_cpu_elig && (!w_vga_elig || w_guard_hit);
   assign w_head_tag = r_tags[r_rptr];

   assign vga_gnt    = w_accept && (r_owner == OWN_VGA);
   assign cpu_gnt    = w_accept && (r_owner == OWN_CPU);
   assign vga_rdata  = sd_rdata;
   assign cpu_rdata  = sd_rdata;
   assign vga_rvalid = w_pop && (w_head_tag == OWN_VGA);
   assign cpu_rvalid = w_pop && (w_head_tag == OWN_CPU);

   assign sd_addr    = r_sd_addr;
   assign sd_be_n    = r_sd_be_n;
   assign sd_rd_n    = r_sd_rd_n;
   assign sd_wr_n    = r_sd_wr_n;
   assign sd_wdata   = r_sd_wdata;
   assign err_orphan = r_err_orphan;

   // Command registers double as the bus drivers, so they stay frozen across waitrequest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_owner    <= OWN_VGA;
         r_we       <= 1'b0;
         r_sd_addr  <= '0;
         r_sd_wdata <= '0;
         r_sd_be_n  <= '1;
         r_sd_rd_n  <= 1'b1;
         r_sd_wr_n  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_vga_elig || w_cpu_elig) begin
                  r_state <= ST_CMD;
                  if (w_pick_cpu) begin
                     r_owner    <= OWN_CPU;
                     r_we       <= cpu_we;
                     r_sd_addr  <= cpu_addr;
                     r_sd_wdata <= cpu_wdata;
                     r_sd_be_n  <= ~cpu_be;
                     r_sd_rd_n  <= cpu_we;
                     r_sd_wr_n  <= ~cpu_we;
                  end else begin
                     r_owner    <= OWN_VGA;
                     r_we       <= 1'b0;
                     r_sd_addr  <= vga_addr;
                     r_sd_wdata <= '0;
                     r_sd_be_n  <= '0;
                     r_sd_rd_n  <= 1'b0;
                     r_sd_wr_n  <= 1'b1;
                  end
               end
            end
            ST_CMD: begin
               if (!sd_waitrequest) begin
                  r_state   <= ST_IDLE;
                  r_sd_rd_n <= 1'b1;
                  r_sd_wr_n <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Read-owner tags; returns are in order so the head tag names the recipient.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tags       <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_err_orphan <= 1'b0;
      end else begin
         if (w_push) begin
            r_tags[r_wptr] <= r_owner;
            r_wptr         <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (sd_rvalid && !w_have) begin
            r_err_orphan <= 1'b1;
         end
      end
   end

`ifdef SDRAM_ARB_STARVATION_GUARD_EN
   localparam int GC_W = $clog2(VGA_BURST_MAX + 1);

   logic [GC_W-1:0] r_guard_cnt;

   assign w_guard_hit = (r_guard_cnt == GC_W'(VGA_BURST_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_guard_cnt <= '0;
      end else if (!cpu_req || cpu_gnt) begin
         r_guard_cnt <= '0;
      end else if (vga_gnt && !w_guard_hit) begin
         r_guard_cnt <= r_guard_cnt + GC_W'(1);
      end
   end
`else
   logic w_unused_cfg;

   assign w_guard_hit  = 1'b0;
   assign w_unused_cfg = (VGA_BURST_MAX > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_sdram_arbiter: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_sdram_arbiter;

   localparam int ADDR_W        = 22;
   localparam int DATA_W        = 16;
   localparam int MAX_PENDING   = 4;
   localparam int VGA_BURST_MAX = 8;
   localparam int NV            = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic [DATA_W-1:0] vga_rdata;
   logic              vga_rvalid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [1:0]        cpu_be;
   logic              cpu_gnt;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic [ADDR_W-1:0] sd_addr;
   logic [1:0]        sd_be_n;
   logic              sd_rd_n;
   logic              sd_wr_n;
   logic [DATA_W-1:0] sd_wdata;
   logic              sd_waitrequest;
   logic [DATA_W-1:0] sd_rdata;
   logic              sd_rvalid;
   logic              err_orphan;

   always #5 clk = ~clk;

   sdram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .VGA_BURST_MAX(VGA_BURST_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .sd_addr(sd_addr), .sd_be_n(sd_be_n), .sd_rd_n(sd_rd_n), .sd_wr_n(sd_wr_n),
      .sd_wdata(sd_wdata), .sd_waitrequest(sd_waitrequest), .sd_rdata(sd_rdata),
      .sd_rvalid(sd_rvalid), .err_orphan(err_orphan)
   );

   typedef struct {
      logic              vga_req;
      logic [ADDR_W-1:0] vga_addr;
      logic              cpu_req;
      logic              cpu_we;
      logic [ADDR_W-1:0] cpu_addr;
      logic [DATA_W-1:0] cpu_wdata;
      logic [1:0]        cpu_be;
      logic              waitreq;
      logic              rvalid;
      logic [DATA_W-1:0] rdata;
      logic              chk_cmd;
      logic              e_rd_n;
      logic              e_wr_n;
      logic [1:0]        e_be_n;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic              e_vgnt;
      logic              e_cgnt;
      logic              e_vrv;
      logic              e_crv;
   } vec_t;

   vec_t tbl [NV];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      vga_req = 1'b0; vga_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      sd_waitrequest = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic vga_issue(input logic [ADDR_W-1:0] a);
      logic got;
      got = 1'b0;
      vga_req = 1'b1;
      vga_addr = a;
      sd_waitrequest = 1'b0;
      for (int t = 0; t < 10; t++) begin
         #3;
         if (vga_gnt) got = 1'b1;
         next_cycle();
         if (got) break;
      end
      vga_req = 1'b0;
      check("vga read grant", 64'(got), 64'(1'b1));
   endtask

   // scenario / model state
   logic              got_c;
   logic              rv;
   int                pend, vcnt, ccnt, v_at_c;
   logic              m_busy, m_owner, m_we, nxt_busy;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [1:0]        m_be_n;
   logic              q [$];
   int                qsz, streak;
   logic              exp_v, exp_c, v_el, c_el, pick_c, guard_hit, drop_v, drop_c;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

   initial begin
      //          vreq  vaddr          creq  cwe   caddr          cwdata    cbe    wait  rv    rdata     chk   rd_n  wr_n  be_n   addr           wdata     vg    cg    vrv   crv
      tbl[0]  = '{1'b0, 22'h000000,    1'b1, 1'b1, 22'h000010,    16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b11, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 22'h000000,    1'b1, 1'b1, 22'h000010,    16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 22'h000010,    16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 22'h0ABCDE,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 22'h0ABCDE,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 22'h0ABCDE,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 22'h0ABCDE,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 22'h0ABCDE,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 22'h0ABCDE,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 22'h0ABCDE,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 22'h0ABCDE,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 22'h0ABCDE,    16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 22'h000000,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 22'h000000,    1'b1, 1'b0, 22'h000123,    16'h0000, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b10, 22'h000123,    16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 22'h000000,    1'b0, 1'b0, 22'h000000,    16'h0000, 2'b00, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 2'b00, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 22'h000000,    1'b0, 1'b0, 22'h000000,    16'h0000, 2'b00, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 2'b00, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 22'h000000,    1'b0, 1'b0, 22'h000000,    16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 22'h000000,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

      do_reset();

      // table: reset state, single write, held VGA command under waitrequest, CPU read, returns
      for (int i = 0; i < NV; i++) begin
         vga_req = tbl[i].vga_req;   vga_addr = tbl[i].vga_addr;
         cpu_req = tbl[i].cpu_req;   cpu_we = tbl[i].cpu_we;   cpu_addr = tbl[i].cpu_addr;
         cpu_wdata = tbl[i].cpu_wdata; cpu_be = tbl[i].cpu_be;
         sd_waitrequest = tbl[i].waitreq; sd_rvalid = tbl[i].rvalid; sd_rdata = tbl[i].rdata;
         #3;
         check($sformatf("vec%0d strobes/gnt/rvalid", i),
               64'({sd_rd_n, sd_wr_n, vga_gnt, cpu_gnt, vga_rvalid, cpu_rvalid}),
               64'({tbl[i].e_rd_n, tbl[i].e_wr_n, tbl[i].e_vgnt, tbl[i].e_cgnt, tbl[i].e_vrv, tbl[i].e_crv}));
         if (tbl[i].chk_cmd)
            check($sformatf("vec%0d addr/be_n", i), 64'({sd_addr, sd_be_n}), 64'({tbl[i].e_addr, tbl[i].e_be_n}));
         if (tbl[i].chk_cmd && !tbl[i].e_wr_n)
            check($sformatf("vec%0d wdata", i), 64'(sd_wdata), 64'(tbl[i].e_wdata));
         if (tbl[i].e_vrv)
            check($sformatf("vec%0d vga_rdata", i), 64'(vga_rdata), 64'(tbl[i].rdata));
         if (tbl[i].e_crv)
            check($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rdata), 64'(tbl[i].rdata));
         next_cycle();
      end
      clear_inputs();

      // four VGA reads fill the tag FIFO; a CPU read must wait for a return
      for (int k = 0; k < 4; k++) vga_issue(22'(32'h100 + k));
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000200; cpu_be = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #3;
         check("full fifo stall", 64'({sd_rd_n, sd_wr_n, vga_gnt, cpu_gnt}), 64'(4'b1100));
         next_cycle();
      end
      got_c = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sd_rvalid = 1'b1;
         sd_rdata = 16'(32'h1111 * (k + 1));
         #3;
         check("vga return steer", 64'({vga_rvalid, cpu_rvalid}), 64'(2'b10));
         check("vga return data", 64'(vga_rdata), 64'(32'h1111 * (k + 1)));
         if (cpu_gnt) got_c = 1'b1;
         next_cycle();
         if (got_c) cpu_req = 1'b0;
      end
      sd_rvalid = 1'b0;
      for (int t = 0; t < 10 && !got_c; t++) begin
         #3;
         if (cpu_gnt) got_c = 1'b1;
         next_cycle();
      end
      cpu_req = 1'b0;
      check("cpu read after drain", 64'(got_c), 64'(1'b1));
      sd_rvalid = 1'b1; sd_rdata = 16'h5555;
      #3;
      check("cpu return steer", 64'({vga_rvalid, cpu_rvalid}), 64'(2'b01));
      check("cpu return data", 64'(cpu_rdata), 64'(16'h5555));
      next_cycle();
      sd_rvalid = 1'b0;

      // orphan return, then reset in the middle of a stalled command
      #3;
      check("err_orphan before", 64'(err_orphan), 64'(1'b0));
      next_cycle();
      sd_rvalid = 1'b1; sd_rdata = 16'hDEAD;
      #3;
      check("orphan no rvalid", 64'({vga_rvalid, cpu_rvalid}), 64'(2'b00));
      next_cycle();
      sd_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #3;
         check("err_orphan sticky", 64'(err_orphan), 64'(1'b1));
         next_cycle();
      end
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h0003FF; cpu_wdata = 16'h1234; cpu_be = 2'b10;
      sd_waitrequest = 1'b1;
      next_cycle();
      #3;
      check("stalled write on bus", 64'({sd_wr_n, sd_be_n, sd_addr}), 64'({1'b0, 2'b01, 22'h0003FF}));
      sd_waitrequest = 1'b0;
      reset = 1'b1;
      #1;
      check("async reset outputs",
            64'({sd_rd_n, sd_wr_n, sd_be_n, vga_gnt, cpu_gnt, err_orphan}), 64'(7'b1111000));
      check("async reset addr/wdata", 64'({sd_addr, sd_wdata}), 64'(0));
      cpu_req = 1'b0;
      next_cycle();
      reset = 1'b0;
      #3;
      check("command abandoned", 64'({sd_rd_n, sd_wr_n, vga_gnt, cpu_gnt}), 64'(4'b1100));
      next_cycle();

      // both requesters held continuously
      do_reset();
      vga_req = 1'b1; vga_addr = 22'h000055;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h000066; cpu_wdata = 16'h7777; cpu_be = 2'b11;
      pend = 0; vcnt = 0; ccnt = 0; v_at_c = -1;
      for (int c = 0; c < 100; c++) begin
         rv = (pend > 0);
         sd_rvalid = rv;
         #3;
         if (rv) pend--;
         if (vga_gnt) begin vcnt++; pend++; end
         if (cpu_gnt) begin
            if (ccnt == 0) v_at_c = vcnt;
            ccnt++;
         end
         next_cycle();
      end
`ifdef SDRAM_ARB_STARVATION_GUARD_EN
      check("guard cpu granted", 64'(ccnt > 0), 64'(1'b1));
      check("guard vga grants before cpu", 64'(v_at_c), 64'(VGA_BURST_MAX));
`else
      check("strict priority cpu grants", 64'(ccnt), 64'(0));
      check("strict priority vga grants", 64'(vcnt), 64'(50));
`endif

      // randomized traffic against a transaction-level model
      do_reset();
      m_busy = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be_n = '0;
      q.delete(); streak = 0; drop_v = 1'b0; drop_c = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (drop_v) begin vga_req = 1'b0; drop_v = 1'b0; end
         if (drop_c) begin cpu_req = 1'b0; drop_c = 1'b0; end
         if (!vga_req && $urandom_range(0, 2) == 0) begin
            vga_req = 1'b1; vga_addr = 22'($urandom);
         end
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 22'($urandom);
            cpu_wdata = 16'($urandom); cpu_be = 2'($urandom);
         end
         qsz = q.size();
         sd_waitrequest = ($urandom_range(0, 9) < 4);
         sd_rvalid = (qsz > 0) && ($urandom_range(0, 9) < 4);
         sd_rdata = 16'($urandom);
         #3;
         exp_v = sd_rvalid && (qsz > 0) && (q[0] == 1'b0);
         exp_c = sd_rvalid && (qsz > 0) && (q[0] == 1'b1);
         check("rand rvalid", 64'({vga_rvalid, cpu_rvalid}), 64'({exp_v, exp_c}));
         if (exp_v) check("rand vga_rdata", 64'(vga_rdata), 64'(sd_rdata));
         if (exp_c) check("rand cpu_rdata", 64'(cpu_rdata), 64'(sd_rdata));
         if (m_busy) begin
            check("rand command bus", 64'({sd_rd_n, sd_wr_n, sd_be_n, sd_addr}),
                  64'({m_we, !m_we, m_be_n, m_addr}));
            if (m_we) check("rand wdata", 64'(sd_wdata), 64'(m_wdata));
            check("rand gnt", 64'({vga_gnt, cpu_gnt}),
                  64'(sd_waitrequest ? 2'b00 : (m_owner ? 2'b01 : 2'b10)));
         end else begin
            check("rand idle", 64'({sd_rd_n, sd_wr_n, vga_gnt, cpu_gnt}), 64'(4'b1100));
         end
`ifdef SDRAM_ARB_STARVATION_GUARD_EN
         guard_hit = (streak >= VGA_BURST_MAX);
`else
         guard_hit = 1'b0;
`endif
         nxt_busy = m_busy;
         if (sd_rvalid && qsz > 0) void'(q.pop_front());
         if (m_busy) begin
            if (!sd_waitrequest) begin
               nxt_busy = 1'b0;
               if (!m_we) q.push_back(m_owner);
               if (m_owner) drop_c = 1'b1; else drop_v = 1'b1;
            end
         end else begin
            v_el = vga_req && (qsz < MAX_PENDING);
            c_el = cpu_req && (cpu_we || qsz < MAX_PENDING);
            pick_c = c_el && (!v_el || guard_hit);
            if (v_el || c_el) begin
               nxt_busy = 1'b1;
               m_owner = pick_c;
               if (pick_c) begin
                  m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; m_be_n = ~cpu_be;
               end else begin
                  m_we = 1'b0; m_addr = vga_addr; m_be_n = 2'b00;
               end
            end
         end
`ifdef SDRAM_ARB_STARVATION_GUARD_EN
         if (!cpu_req || cpu_gnt) streak = 0;
         else if (vga_gnt && streak < VGA_BURST_MAX) streak++;
`endif
         m_busy = nxt_busy;
         next_cycle();
      end
      #3;
      check("rand no orphan", 64'(err_orphan), 64'(1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
